// File: rtl/guess_pkg.sv
// guess_pkg: ASCII constants and letter helpers shared by the guess FIFO
package guess_pkg;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_Z     = 8'h5A;
    localparam logic [7:0] ASCII_a     = 8'h61;
    localparam logic [7:0] ASCII_z     = 8'h7A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    function automatic logic is_lower(input logic [7:0] b);
        return (b >= ASCII_a) && (b <= ASCII_z);
    endfunction

    function automatic logic is_letter(input logic [7:0] b);
        return ((b >= ASCII_A) && (b <= ASCII_Z)) || is_lower(b);
    endfunction

    function automatic logic [7:0] to_upper(input logic [7:0] b);
        return is_lower(b) ? b - CASE_OFFSET : b;
    endfunction
endpackage

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: show-ahead FIFO storage with registered head output
module sync_fifo_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    // next pointers/count; head register forwards the incoming byte when it becomes the head
    always_comb begin
        wptr_d  = clear_i ? '0 : push_i ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = clear_i ? '0 : pop_i ? rptr_q + AW'(1) : rptr_q;
        count_d = clear_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
        dout_d  = (!clear_i && count_d != '0)
                ? ((push_i && wptr_q == rptr_d) ? din_i : mem_q[rptr_d])
                : dout_q;
    end

    // storage is never reset or cleared; validity comes from count
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= din_i;
    end

    // pointer, count and head registers
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    assign dout_o  = dout_q;
    assign count_o = count_q;
    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
endmodule

// File: rtl/guess_fifo.sv
// guess_fifo: buffers UART bytes for the game FSM with edge capture and letter filtering
module guess_fifo
    import guess_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int FILTER_EN = 1,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             ready,
    input  logic [WIDTH-1:0] Rx_byte,
    input  logic             game_rdy,
    input  logic             clear,
    output logic [WIDTH-1:0] guess,
    output logic             guess_valid,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             overflow,
    output logic             reject
);
    logic             ready_q, reject_q, overflow_q, overflow_d;
    logic             cap, pass, push, pop, drop, empty;
    logic [WIDTH-1:0] data;

    if (FILTER_EN != 0) begin : g_filt
        assign pass = is_letter(Rx_byte[7:0]);
        assign data = WIDTH'(to_upper(Rx_byte[7:0]));
    end else begin : g_raw
        assign pass = 1'b1;
        assign data = Rx_byte;
    end

    // capture on ready rising edge; a pop frees the slot for a same-cycle push when full
    always_comb begin
        cap        = ready & ~ready_q;
        pop        = game_rdy & ~empty & ~clear;
        push       = cap & pass & (~full | pop) & ~clear;
        drop       = cap & pass & full & ~pop & ~clear;
        overflow_d = clear ? 1'b0 : overflow_q | drop;
    end

    // edge detector, reject pulse and sticky overflow
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            ready_q    <= 1'b0;
            reject_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            ready_q    <= ready;
            reject_q   <= cap & ~pass;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo_core #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_core (
        .clk     (clk),
        .nRst    (nRst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (clear),
        .din_i   (data),
        .dout_o  (guess),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign guess_valid = ~empty;
    assign overflow    = overflow_q;
    assign reject      = reject_q;
endmodule

// File: tb/tb_guess_fifo.sv
// tb_guess_fifo: randomized and directed checks of guess_fifo against a queue model
module tb_guess_fifo;
    logic       clk = 1'b0, nRst = 1'b0, ready = 1'b0, game_rdy = 1'b0, clear = 1'b0;
    logic [7:0] Rx_byte = 8'h00;
    logic [7:0] guess0, guess1;
    logic [2:0] count0, count1;
    logic       gv0, gv1, full0, full1, ov0, ov1, rej0, rej1;

    guess_fifo #(.WIDTH(8), .DEPTH(4), .FILTER_EN(1)) u0 (
        .clk(clk), .nRst(nRst), .ready(ready), .Rx_byte(Rx_byte), .game_rdy(game_rdy),
        .clear(clear), .guess(guess0), .guess_valid(gv0), .count(count0), .full(full0),
        .overflow(ov0), .reject(rej0));

    guess_fifo #(.WIDTH(8), .DEPTH(4), .FILTER_EN(0)) u1 (
        .clk(clk), .nRst(nRst), .ready(ready), .Rx_byte(Rx_byte), .game_rdy(game_rdy),
        .clear(clear), .guess(guess1), .guess_valid(gv1), .count(count1), .full(full1),
        .overflow(ov1), .reject(rej1));

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [7:0] q0[$], q1[$];
    logic [7:0] h0 = 8'h00, h1 = 8'h00;
    bit m_ov0 = 0, m_ov1 = 0, m_rej = 0, m_prev = 0;

    function automatic bit letter(input logic [7:0] b);
        return (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    function automatic logic [7:0] upper(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete();
        h0 = 8'h00; h1 = 8'h00;
        m_ov0 = 0; m_ov1 = 0; m_rej = 0; m_prev = 0;
    endtask

    // apply the current inputs to the model as if a clock edge occurred
    task automatic model_edge();
        bit cap;
        logic [7:0] tmp;
        cap = ready && !m_prev;
        if (clear) begin
            q0.delete(); q1.delete();
            m_ov0 = 0; m_ov1 = 0;
        end else begin
            if (game_rdy && q0.size() > 0) tmp = q0.pop_front();
            if (game_rdy && q1.size() > 0) tmp = q1.pop_front();
            if (cap && letter(Rx_byte)) begin
                if (q0.size() < 4) q0.push_back(upper(Rx_byte)); else m_ov0 = 1;
            end
            if (cap) begin
                if (q1.size() < 4) q1.push_back(Rx_byte); else m_ov1 = 1;
            end
        end
        if (q0.size() > 0) h0 = q0[0];
        if (q1.size() > 0) h1 = q1[0];
        m_rej = cap && !letter(Rx_byte);
        m_prev = ready;
    endtask

    task automatic check_all();
        chk("count0", 32'(count0), 32'(q0.size()));
        chk("valid0", 32'(gv0), 32'(q0.size() != 0));
        chk("full0", 32'(full0), 32'(q0.size() == 4));
        chk("guess0", 32'(guess0), 32'(h0));
        chk("ovf0", 32'(ov0), 32'(m_ov0));
        chk("reject0", 32'(rej0), 32'(m_rej));
        chk("count1", 32'(count1), 32'(q1.size()));
        chk("guess1", 32'(guess1), 32'(h1));
        chk("ovf1", 32'(ov1), 32'(m_ov1));
        chk("reject1", 32'(rej1), 32'd0);
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic push(input logic [7:0] b, input bit gr);
        Rx_byte = b; ready = 1'b1; game_rdy = gr;
        cyc();
        ready = 1'b0; game_rdy = 1'b0;
        cyc();
    endtask

    task automatic pop1();
        game_rdy = 1'b1;
        cyc();
        game_rdy = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        nRst = 1'b1;
        #1;
        chk("rst_valid", 32'(gv0), 32'd0);
        chk("rst_count", 32'(count0), 32'd0);
        chk("rst_guess", 32'(guess0), 32'd0);
        cyc(); cyc();

        Rx_byte = 8'h68; ready = 1'b1;
        repeat (5) cyc();
        ready = 1'b0;
        cyc();
        chk("lvl_count", 32'(count0), 32'd1);
        chk("lvl_guess", 32'(guess0), 32'h48);

        push(8'h35, 1'b0);
        chk("flt_count", 32'(count0), 32'd1);
        pop1(); cyc();
        chk("raw_guess", 32'(guess1), 32'h35);
        chk("flt_empty", 32'(gv0), 32'd0);

        clear = 1'b1; cyc(); clear = 1'b0; cyc();
        for (int i = 0; i < 4; i++) push(8'h41 + 8'(i), 1'b0);
        chk("fill_full", 32'(full0), 32'd1);
        push(8'h45, 1'b0);
        chk("drop_ovf", 32'(ov0), 32'd1);
        chk("drop_count", 32'(count0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("pop_seq", 32'(guess0), 32'h41 + 32'(i));
            pop1();
        end
        chk("drained", 32'(gv0), 32'd0);
        cyc();

        clear = 1'b1; cyc(); clear = 1'b0; cyc();
        for (int i = 0; i < 4; i++) push(8'h41 + 8'(i), 1'b0);
        push(8'h46, 1'b1);
        chk("pp_count", 32'(count0), 32'd4);
        chk("pp_ovf", 32'(ov0), 32'd0);
        chk("pp_head", 32'(guess0), 32'h42);
        for (int i = 0; i < 3; i++) pop1();
        chk("pp_tail", 32'(guess0), 32'h46);

        clear = 1'b1; cyc(); clear = 1'b0; cyc();
        for (int i = 0; i < 3; i++) push(8'h61 + 8'(i), 1'b0);
        Rx_byte = 8'h47; ready = 1'b1; clear = 1'b1;
        cyc();
        clear = 1'b0; ready = 1'b0;
        cyc();
        chk("clr_count", 32'(count0), 32'd0);
        chk("clr_ovf", 32'(ov0), 32'd0);

        for (int n = 0; n < 400; n++) begin
            ready    = 1'($urandom_range(0, 1));
            game_rdy = ($urandom_range(0, 3) == 0);
            clear    = ($urandom_range(0, 39) == 0);
            Rx_byte  = ($urandom_range(0, 1) == 1)
                     ? (8'h41 + 8'($urandom_range(0, 25)) + (($urandom_range(0, 1) == 1) ? 8'h20 : 8'h00))
                     : 8'($urandom);
            cyc();
        end
        ready = 1'b0; game_rdy = 1'b0; clear = 1'b0;
        cyc();

        for (int i = 0; i < 3; i++) push(8'h50 + 8'(i), 1'b0);
        @(posedge clk);
        #3 nRst = 1'b0;
        #1;
        chk("arst_valid", 32'(gv0), 32'd0);
        chk("arst_count", 32'(count0), 32'd0);
        chk("arst_guess", 32'(guess0), 32'd0);
        chk("arst_full", 32'(full0), 32'd0);
        model_reset();
        @(negedge clk);
        nRst = 1'b1;
        cyc();
        push(8'h7A, 1'b0);
        chk("post_guess", 32'(guess0), 32'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
